// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the memory port arbiter and the unified memory.
// master = pipeline stages plus memory, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              stall_if;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              stall_mem;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, stall_if, d_rdata, d_done, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, stall_if, d_rdata, d_done, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF (fetch) and MEM (load/store) with fixed-latency sequencing.
// Define ARB_STARVE_GUARD_EN to add the fetch starvation guard; default build is strict data priority.
//
// state  | meaning
// IDLE   | port free, arbitrate between d_req and if_req
// ACCESS | mem_en held for LATENCY cycles, read data captured on the last one
// RESP   | owner's done pulses, no arbitration
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    if (LATENCY < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: LATENCY and STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              owner_d;
    logic              grant_d, grant_f, last_beat;
    logic              fetch_turn;

    logic              mem_en_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r, d_rdata_r;
    logic              if_done_r, d_done_r;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    assign fetch_turn = (starve_cnt == SC_W'(STARVE_MAX));

    // Only touched at arbitration; it can never pass STARVE_MAX because that value forces a fetch grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_f || !bus.if_req) begin
                starve_cnt <= '0;
            end else if (grant_d) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign fetch_turn = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_f) state_nxt = ACCESS;
            ACCESS:  if (last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        last_beat = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && fetch_turn)) begin
                    grant_d = 1'b1;
                end else if (bus.if_req) begin
                    grant_f = 1'b1;
                end
            end
            ACCESS:  last_beat = (cnt == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            owner_d     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_rdata_r  <= '0;
            d_rdata_r   <= '0;
            if_done_r   <= 1'b0;
            d_done_r    <= 1'b0;
        end else begin
            if_done_r <= 1'b0;
            d_done_r  <= 1'b0;
            if (grant_d || grant_f) begin
                owner_d    <= grant_d;
                mem_en_r   <= 1'b1;
                mem_we_r   <= grant_d & bus.d_we;
                mem_addr_r <= grant_d ? bus.d_addr : bus.if_addr;
                if (grant_d) begin
                    mem_wdata_r <= bus.d_wdata;
                end
                cnt <= CNT_W'(LATENCY - 1);
            end else if (state == ACCESS) begin
                if (last_beat) begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    // mem_we_r still holds the access type here; stores keep d_rdata
                    if (owner_d) begin
                        d_done_r <= 1'b1;
                        if (!mem_we_r) begin
                            d_rdata_r <= bus.mem_rdata;
                        end
                    end else begin
                        if_done_r  <= 1'b1;
                        if_rdata_r <= bus.mem_rdata;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.d_done    = d_done_r;
    assign bus.stall_if  = bus.if_req & ~if_done_r;
    assign bus.stall_mem = bus.d_req & ~d_done_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-scenario tasks, scoreboard queue of expected completions.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LATENCY    = 2;
    localparam int STARVE_MAX = 2;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc;
    logic [31:0] exp_d_rdata;
    exp_t sb[$];

    logic [31:0] mem_model [256];
    logic        written   [256];
    int          en_run = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (written[a[9:2]] === 1'b1) return mem_model[a[9:2]];
        if (a == 32'h40) return 32'h1234_5678;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: data is only valid on the last enabled cycle, garbage before it
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem_model[bus.mem_addr[9:2]] <= bus.mem_wdata;
            written[bus.mem_addr[9:2]]   <= 1'b1;
        end
        en_run <= bus.mem_en ? en_run + 1 : 0;
    end

    assign bus.mem_rdata = (bus.mem_en && en_run == LATENCY - 1) ? model_rd(bus.mem_addr)
                                                                 : (32'hBAD0_0000 | 32'(en_run));

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        @(negedge clk);
        n_total++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en got %0b want 0", bus.mem_en); else n_pass++;
        n_total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %0b want 0", bus.mem_we); else n_pass++;
        n_total++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); else n_pass++;
        n_total++; if (bus.if_rdata !== 32'h0) $display("FAIL reset_if_rdata got %h want 0", bus.if_rdata); else n_pass++;
        n_total++; if (bus.d_rdata !== 32'h0) $display("FAIL reset_d_rdata got %h want 0", bus.d_rdata); else n_pass++;
        n_total++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0)
            $display("FAIL reset_done got if=%0b d=%0b want 0 0", bus.if_done, bus.d_done); else n_pass++;
        n_total++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b0)
            $display("FAIL reset_stall got if=%0b mem=%0b want 1 0", bus.stall_if, bus.stall_mem); else n_pass++;
        exp_d_rdata = 32'h0;
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch_read();
        exp_t e;
        cyc = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        sb.push_back({1'b0, model_rd(32'h40)});
        while (cyc < 7) begin
            @(negedge clk);
            n_total++; if (bus.mem_en !== (cyc == 1 || cyc == 2))
                $display("FAIL fetch_mem_en cyc %0d got %0b", cyc, bus.mem_en); else n_pass++;
            n_total++; if (bus.stall_if !== (cyc <= 2))
                $display("FAIL fetch_stall_if cyc %0d got %0b", cyc, bus.stall_if); else n_pass++;
            n_total++; if (bus.if_done !== (cyc == 3) || bus.d_done !== 1'b0)
                $display("FAIL fetch_done cyc %0d got if=%0b d=%0b", cyc, bus.if_done, bus.d_done); else n_pass++;
            if (cyc == 1) begin
                n_total++; if (bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0)
                    $display("FAIL fetch_mem_addr got %h we=%0b want 00000040 we=0", bus.mem_addr, bus.mem_we); else n_pass++;
            end
            if (bus.if_done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++; if (e.is_d !== 1'b0 || bus.if_rdata !== e.data)
                    $display("FAIL fetch_rdata got %h want %h", bus.if_rdata, e.data); else n_pass++;
            end
            next_cycle();
            if (cyc == 4) bus.if_req = 1'b0;
        end
        n_total++; if (sb.size() != 0) $display("FAIL fetch_pending got %0d want 0", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_store();
        exp_t e;
        cyc = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        sb.push_back({1'b1, exp_d_rdata});
        while (cyc < 7) begin
            @(negedge clk);
            n_total++; if (bus.mem_en !== (cyc == 1 || cyc == 2) || bus.mem_we !== (cyc == 1 || cyc == 2))
                $display("FAIL store_en_we cyc %0d got en=%0b we=%0b", cyc, bus.mem_en, bus.mem_we); else n_pass++;
            if (cyc == 1 || cyc == 2) begin
                n_total++; if (bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEAD_BEEF)
                    $display("FAIL store_bus cyc %0d got %h/%h want 00000100/deadbeef", cyc, bus.mem_addr, bus.mem_wdata); else n_pass++;
            end
            n_total++; if (bus.d_done !== (cyc == 3) || bus.stall_mem !== (cyc <= 2))
                $display("FAIL store_done cyc %0d got done=%0b stall=%0b", cyc, bus.d_done, bus.stall_mem); else n_pass++;
            if (bus.d_done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++; if (e.is_d !== 1'b1 || bus.d_rdata !== e.data)
                    $display("FAIL store_d_rdata got %h want %h", bus.d_rdata, e.data); else n_pass++;
            end
            next_cycle();
            if (cyc == 4) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
        end
        n_total++; if (sb.size() != 0) $display("FAIL store_pending got %0d want 0", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_collision();
        exp_t e;
        cyc = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        sb.push_back({1'b1, model_rd(32'h100)});
        sb.push_back({1'b0, model_rd(32'h44)});
        while (cyc < 10) begin
            @(negedge clk);
            n_total++; if (bus.mem_en !== (cyc == 1 || cyc == 2 || cyc == 5 || cyc == 6))
                $display("FAIL coll_mem_en cyc %0d got %0b", cyc, bus.mem_en); else n_pass++;
            n_total++; if (bus.d_done !== (cyc == 3) || bus.if_done !== (cyc == 7))
                $display("FAIL coll_done cyc %0d got d=%0b if=%0b", cyc, bus.d_done, bus.if_done); else n_pass++;
            n_total++; if (bus.stall_if !== (cyc <= 6))
                $display("FAIL coll_stall_if cyc %0d got %0b", cyc, bus.stall_if); else n_pass++;
            if (cyc == 5) begin
                n_total++; if (bus.mem_addr !== 32'h44)
                    $display("FAIL coll_fetch_addr got %h want 00000044", bus.mem_addr); else n_pass++;
            end
            if ((bus.d_done === 1'b1 || bus.if_done === 1'b1) && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (e.is_d !== bus.d_done || (e.is_d ? bus.d_rdata : bus.if_rdata) !== e.data)
                    $display("FAIL coll_order got d=%0b data=%h want d=%0b data=%h", bus.d_done,
                             e.is_d ? bus.d_rdata : bus.if_rdata, e.is_d, e.data);
                else n_pass++;
                if (e.is_d) exp_d_rdata = e.data;
            end
            next_cycle();
            if (cyc == 4) bus.d_req = 1'b0;
            if (cyc == 8) bus.if_req = 1'b0;
        end
        n_total++; if (sb.size() != 0) $display("FAIL coll_pending got %0d want 0", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_starvation();
        exp_t e;
        int   n_done = 0;
        bit   pattern [6];
`ifdef ARB_STARVE_GUARD_EN
        pattern = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        pattern = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        cyc = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        for (int i = 0; i < 6; i++) sb.push_back({pattern[i], pattern[i] ? model_rd(32'h100) : model_rd(32'h48)});
        while (n_done < 6 && cyc < 40) begin
            @(negedge clk);
            if (bus.d_done === 1'b1 || bus.if_done === 1'b1) begin
                n_total++; if (cyc != 3 + (LATENCY + 2) * n_done || (bus.d_done & bus.if_done))
                    $display("FAIL starve_timing grant %0d got cyc %0d want %0d", n_done, cyc, 3 + (LATENCY + 2) * n_done);
                else n_pass++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_total++;
                    if (e.is_d !== bus.d_done || (e.is_d ? bus.d_rdata : bus.if_rdata) !== e.data)
                        $display("FAIL starve_grant %0d got d=%0b want d=%0b", n_done, bus.d_done, e.is_d);
                    else n_pass++;
                    if (e.is_d) exp_d_rdata = e.data;
                end
                n_done++;
            end
            next_cycle();
        end
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        n_total++; if (n_done != 6) $display("FAIL starve_timeout got %0d dones want 6", n_done); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            n_total++; if (bus.d_done !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_en !== 1'b0)
                $display("FAIL starve_quiet got d=%0b if=%0b en=%0b", bus.d_done, bus.if_done, bus.mem_en); else n_pass++;
            next_cycle();
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        cyc = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        sb.push_back({1'b1, model_rd(32'h80)});
        while (cyc < 9) begin
            @(negedge clk);
            n_total++; if (bus.mem_en !== (cyc == 1 || cyc == 4 || cyc == 5))
                $display("FAIL rst_mid_mem_en cyc %0d got %0b", cyc, bus.mem_en); else n_pass++;
            n_total++; if (bus.d_done !== (cyc == 6))
                $display("FAIL rst_mid_d_done cyc %0d got %0b", cyc, bus.d_done); else n_pass++;
            if (cyc == 2) begin
                n_total++; if (bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h0 || bus.mem_addr !== 32'h0)
                    $display("FAIL rst_mid_regs got d=%h if=%h addr=%h want 0", bus.d_rdata, bus.if_rdata, bus.mem_addr);
                else n_pass++;
                exp_d_rdata = 32'h0;
            end
            if (bus.d_done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++; if (bus.d_rdata !== e.data)
                    $display("FAIL rst_mid_rdata got %h want %h", bus.d_rdata, e.data); else n_pass++;
                exp_d_rdata = e.data;
            end
            next_cycle();
            if (cyc == 2) reset = 1'b1;
            if (cyc == 3) reset = 1'b0;
            if (cyc == 7) bus.d_req = 1'b0;
        end
        n_total++; if (sb.size() != 0) $display("FAIL rst_mid_pending got %0d want 0", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n_done = 0;
        bit   was_done = 1'b0;
        cyc = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        for (int i = 0; i < 3; i++) sb.push_back({1'b0, model_rd(32'h200 + 32'(4 * i))});
        while (cyc < 15) begin
            @(negedge clk);
            was_done = bus.if_done;
            n_total++; if (bus.if_done !== (cyc == 3 || cyc == 7 || cyc == 11))
                $display("FAIL b2b_if_done cyc %0d got %0b", cyc, bus.if_done); else n_pass++;
            if (cyc == 1 || cyc == 5 || cyc == 9) begin
                n_total++; if (bus.mem_addr !== 32'h200 + 32'(cyc - 1))
                    $display("FAIL b2b_mem_addr cyc %0d got %h want %h", cyc, bus.mem_addr, 32'h200 + 32'(cyc - 1));
                else n_pass++;
            end
            if (bus.if_done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_total++; if (bus.if_rdata !== e.data)
                    $display("FAIL b2b_rdata %0d got %h want %h", n_done, bus.if_rdata, e.data); else n_pass++;
                n_done++;
            end
            next_cycle();
            if (was_done) begin
                if (n_done < 3) bus.if_addr = bus.if_addr + 32'h4;
                else bus.if_req = 1'b0;
            end
        end
        n_total++; if (n_done != 3 || sb.size() != 0)
            $display("FAIL b2b_count got %0d dones want 3", n_done); else n_pass++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store();
        test_collision();
        test_starvation();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
